// File: rtl/dec_trace_fifo_pkg.sv
// -----------------------------------------------------------------------------
// dec_trace_fifo_pkg
//   Shared types for the retire-trace FIFO slice.
//   - trace_pkt_t : per-cycle retire trace from decode/TLU (3 lanes).
//   - trace_rec_t : one buffered retired-instruction record.
//   - popcount3() : number of valid lanes in a packet.
//   Optional macro: RV_TRACE_TIMESTAMP_EN prepends a 32-bit ts field to
//   trace_rec_t (136-bit record); without it the record is 104 bits.
// -----------------------------------------------------------------------------
package dec_trace_fifo_pkg;

  localparam int NLANES = 3;

  typedef struct packed {
    logic [95:0] trace_rv_i_insn_ip;       // lane n at [32n+31:32n]
    logic [95:0] trace_rv_i_address_ip;    // lane n at [32n+31:32n]
    logic [2:0]  trace_rv_i_valid_ip;
    logic [2:0]  trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;     // shared by all lanes
    logic [2:0]  trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;       // shared by all lanes
  } trace_pkt_t;

  typedef struct packed {
`ifdef RV_TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
    logic        ovf;
    logic        intr;
    logic        exc;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic [31:0] addr;
    logic [31:0] insn;
  } trace_rec_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/dec_trace_fifo_if.sv
// -----------------------------------------------------------------------------
// dec_trace_fifo_if
//   Valid/ready trace output port of the retire-trace FIFO.
//   - out_valid : head record valid        (master -> slave)
//   - out_rec   : head record              (master -> slave)
//   - out_ready : sink accepts head record (slave -> master)
// -----------------------------------------------------------------------------
interface dec_trace_fifo_if;
  import dec_trace_fifo_pkg::*;

  logic       out_valid;
  logic       out_ready;
  trace_rec_t out_rec;

  modport master (output out_valid, output out_rec, input out_ready);
  modport slave  (input out_valid, input out_rec, output out_ready);

endinterface

// File: rtl/dec_trace_fifo_mem.sv
// -----------------------------------------------------------------------------
// dec_trace_fifo_mem
//   Record storage: DEPTH x trace_rec_t register array with three write
//   ports at consecutive (modulo DEPTH) addresses and one combinational
//   read port.
//   - clk   : clock
//   - we    : per-slot write enable; slot k writes waddr+k
//   - waddr : base write index
//   - wdata : slot data
//   - raddr : read index
//   - rdata : record at raddr (combinational)
// -----------------------------------------------------------------------------
module dec_trace_fifo_mem
  import dec_trace_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [2:0]    we,
  input  logic [AW-1:0] waddr,
  input  trace_rec_t    wdata [NLANES],
  input  logic [AW-1:0] raddr,
  output trace_rec_t    rdata
);

  trace_rec_t mem [DEPTH];

  // NOTE: the data array has no reset; the parent's pointers decide which
  // entries are meaningful, so clearing storage would only cost logic.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NLANES; k++) begin
      // Index arithmetic wraps at DEPTH, so a burst may straddle DEPTH-1 -> 0.
      if (we[k]) mem[waddr + AW'(k)] <= wdata[k];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dec_trace_fifo.sv
// -----------------------------------------------------------------------------
// dec_trace_fifo
//   Buffers up to 3 retired-instruction records per cycle from the retire
//   trace packet into a circular FIFO and drains one per cycle to a
//   valid/ready trace port. The retire pipe never stalls: a packet that
//   does not fit is dropped whole, counted, and the next accepted record
//   carries ovf=1.
//   Ports:
//   - clk, rst    : clock, synchronous active-high reset
//   - trace_en    : capture enable (FIFO drains regardless)
//   - flush       : synchronous clear of FIFO, drop counter, overflow flag
//   - trace_pkt   : per-cycle retire trace
//   - trace_port  : output port (out_valid/out_ready/out_rec)
//   - drop_cnt    : saturating count of dropped packets
//   - fifo_count  : current occupancy
//   Parameters: DEPTH (power of two, >= 4), DCNT_W.
//   Optional macro: RV_TRACE_TIMESTAMP_EN adds a free-running cycle counter
//   whose value is stamped into every record of a push.
// -----------------------------------------------------------------------------
module dec_trace_fifo
  import dec_trace_fifo_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DCNT_W = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int PW     = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trace_en,
  input  logic                  flush,
  input  trace_pkt_t            trace_pkt,
  dec_trace_fifo_if.master      trace_port,
  output logic [DCNT_W-1:0]     drop_cnt,
  output logic [PW-1:0]         fifo_count
);

  // Pointers carry one extra MSB so full (count==DEPTH) and empty differ.
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          ovf_pend;

  logic [1:0]    nv;
  logic          push_ok;
  logic          push_drop;
  logic          pop;
  logic [2:0]    we;
  logic [1:0]    sel [NLANES];
  trace_rec_t    wdata [NLANES];
  trace_rec_t    rd_rec;

`ifdef RV_TRACE_TIMESTAMP_EN
  logic [31:0]   ts_q;

  // Free-running cycle counter; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 32'd1;
  end
`endif

  function automatic trace_rec_t lane_rec(input trace_pkt_t p, input logic [1:0] lane);
    trace_rec_t r;
    r        = '0;
    r.insn   = p.trace_rv_i_insn_ip[32*int'(lane) +: 32];
    r.addr   = p.trace_rv_i_address_ip[32*int'(lane) +: 32];
    r.exc    = p.trace_rv_i_exception_ip[lane];
    r.intr   = p.trace_rv_i_interrupt_ip[lane];
    r.ecause = p.trace_rv_i_ecause_ip;
    r.tval   = p.trace_rv_i_tval_ip;
    return r;
  endfunction

  assign nv         = trace_en ? popcount3(trace_pkt.trace_rv_i_valid_ip) : 2'd0;
  assign fifo_count = wptr - rptr;

  // Space is judged on pre-pop occupancy; a same-cycle pop never makes room.
  assign push_ok   = (nv != 2'd0) &&
                     (({1'b0, fifo_count} + (PW+1)'(nv)) <= (PW+1)'(DEPTH));
  assign push_drop = (nv != 2'd0) && !push_ok;

  assign trace_port.out_valid = (fifo_count != '0);
  assign trace_port.out_rec   = trace_port.out_valid ? rd_rec : '0;
  assign pop                  = trace_port.out_valid && trace_port.out_ready;

  // Lane compaction: slot k takes the k-th valid lane in ascending order.
  // Slot 1 is only used with two or more valid lanes, slot 2 only with all three.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path can leave a value held, which would infer a latch.
  always_comb begin
    sel[0] = 2'd2;
    sel[1] = 2'd2;
    sel[2] = 2'd2;
    if (trace_pkt.trace_rv_i_valid_ip[0])      sel[0] = 2'd0;
    else if (trace_pkt.trace_rv_i_valid_ip[1]) sel[0] = 2'd1;
    if (trace_pkt.trace_rv_i_valid_ip[0] && trace_pkt.trace_rv_i_valid_ip[1]) sel[1] = 2'd1;

    for (int k = 0; k < NLANES; k++) begin
      wdata[k] = lane_rec(trace_pkt, sel[k]);
`ifdef RV_TRACE_TIMESTAMP_EN
      wdata[k].ts = ts_q;
`endif
    end
    // Only the first record of an accepted push reports a prior drop.
    wdata[0].ovf = ovf_pend;

    we = 3'b000;
    if (push_ok && !flush && !rst) begin
      case (nv)
        2'd1:    we = 3'b001;
        2'd2:    we = 3'b011;
        2'd3:    we = 3'b111;
        default: we = 3'b000;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr     <= '0;
      rptr     <= '0;
      drop_cnt <= '0;
      ovf_pend <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr     <= wptr + PW'(nv);
        ovf_pend <= 1'b0;
      end else if (push_drop) begin
        ovf_pend <= 1'b1;
        if (~&drop_cnt) drop_cnt <= drop_cnt + DCNT_W'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
    end
  end

  dec_trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_rec)
  );

endmodule

// File: tb/tb_dec_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_dec_trace_fifo
//   Self-checking bench for dec_trace_fifo (DEPTH=16, DCNT_W=16). A queue of
//   records, a drop count and a pending-overflow bit form the reference
//   model; directed scenarios are followed by a randomized phase.
//   Honors RV_TRACE_TIMESTAMP_EN when defined for the whole build.
// -----------------------------------------------------------------------------
module tb_dec_trace_fifo;
  import dec_trace_fifo_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DCNT_W = 16;
  localparam int DMAX   = (1 << DCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              trace_en;
  logic              flush;
  trace_pkt_t        trace_pkt;
  logic [DCNT_W-1:0] drop_cnt;
  logic [4:0]        fifo_count;

  dec_trace_fifo_if tif ();

  dec_trace_fifo #(.DEPTH(DEPTH), .DCNT_W(DCNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_en   (trace_en),
    .flush      (flush),
    .trace_pkt  (trace_pkt),
    .trace_port (tif),
    .drop_cnt   (drop_cnt),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  trace_rec_t  mq [$];
  int          m_drops;
  bit          m_pend;
  logic [31:0] m_ts;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic trace_pkt_t mk_pkt(input logic [2:0] v);
    trace_pkt_t p;
    p.trace_rv_i_insn_ip      = {$urandom, $urandom, $urandom};
    p.trace_rv_i_address_ip   = {$urandom, $urandom, $urandom};
    p.trace_rv_i_valid_ip     = v;
    p.trace_rv_i_exception_ip = 3'($urandom);
    p.trace_rv_i_ecause_ip    = 5'($urandom);
    p.trace_rv_i_interrupt_ip = 3'($urandom);
    p.trace_rv_i_tval_ip      = $urandom;
    return p;
  endfunction

  function automatic trace_rec_t lane_rec(input trace_pkt_t p, input int n);
    trace_rec_t r;
    r        = '0;
    r.insn   = p.trace_rv_i_insn_ip[32*n +: 32];
    r.addr   = p.trace_rv_i_address_ip[32*n +: 32];
    r.exc    = p.trace_rv_i_exception_ip[n];
    r.intr   = p.trace_rv_i_interrupt_ip[n];
    r.ecause = p.trace_rv_i_ecause_ip;
    r.tval   = p.trace_rv_i_tval_ip;
    return r;
  endfunction

  // One clock: drive inputs, compare outputs against the model on the
  // falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic f, input logic en,
                       input trace_pkt_t p, input logic rdy);
    trace_rec_t exp_rec;
    trace_rec_t rec;
    int         nv;
    int         pre;
    bit         first;
    rst = r; flush = f; trace_en = en; trace_pkt = p; tif.out_ready = rdy;
    @(negedge clk);
    exp_rec = (mq.size() != 0) ? mq[0] : '0;
    check("out_valid",  160'(tif.out_valid), 160'(mq.size() != 0));
    check("out_rec",    160'(tif.out_rec),   160'(exp_rec));
    check("fifo_count", 160'(fifo_count),    160'(mq.size()));
    check("drop_cnt",   160'(drop_cnt),      160'(m_drops));
    if (r) begin
      mq.delete(); m_drops = 0; m_pend = 0; m_ts = '0;
    end else begin
      if (f) begin
        mq.delete(); m_drops = 0; m_pend = 0;
      end else begin
        nv  = en ? $countones(p.trace_rv_i_valid_ip) : 0;
        pre = mq.size();
        if (nv != 0 && pre + nv <= DEPTH) begin
          first = 1'b1;
          for (int n = 0; n < 3; n++) begin
            if (p.trace_rv_i_valid_ip[n]) begin
              rec     = lane_rec(p, n);
              rec.ovf = first && m_pend;
`ifdef RV_TRACE_TIMESTAMP_EN
              rec.ts  = m_ts;
`endif
              mq.push_back(rec);
              first = 1'b0;
            end
          end
          m_pend = 0;
        end else if (nv != 0) begin
          if (m_drops < DMAX) m_drops++;
          m_pend = 1;
        end
        if (pre != 0 && rdy) void'(mq.pop_front());
      end
      m_ts = m_ts + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  trace_pkt_t idle;
  trace_pkt_t p;
  trace_pkt_t wp;
`ifdef RV_TRACE_TIMESTAMP_EN
  logic [31:0] ts0, ts1, ts2, ts3;
`endif

  initial begin
    idle = mk_pkt(3'b000);
    rst = 1'b1; flush = 1'b0; trace_en = 1'b0; trace_pkt = idle; tif.out_ready = 1'b0;
    mq.delete(); m_drops = 0; m_pend = 0; m_ts = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_valid", 160'(tif.out_valid), 160'(0));
    check("rst_count", 160'(fifo_count),    160'(0));
    check("rst_drop",  160'(drop_cnt),      160'(0));
    check("rst_rec",   160'(tif.out_rec),   160'(0));

    // Lanes 0 and 2 valid, no hole between them
    p = mk_pkt(3'b101);
    p.trace_rv_i_insn_ip[31:0]  = 32'h0000_0013;
    p.trace_rv_i_insn_ip[95:64] = 32'h0010_0093;
    cycle(0, 0, 1, p, 0);
    check("two_lane_count", 160'(fifo_count),       160'(2));
    check("first_insn",     160'(tif.out_rec.insn), 160'(32'h0000_0013));
    check("first_ovf",      160'(tif.out_rec.ovf),  160'(0));
    cycle(0, 0, 1, idle, 1);
    check("second_insn",    160'(tif.out_rec.insn), 160'(32'h0010_0093));
    cycle(0, 0, 1, idle, 1);
    check("drained_count",  160'(fifo_count),       160'(0));

    // Overflow: 5 full pushes reach 15, the 6th is dropped
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, mk_pkt(3'b111), 0);
    check("fill15", 160'(fifo_count), 160'(15));
    cycle(0, 0, 1, mk_pkt(3'b111), 0);
    check("drop1_cnt",   160'(drop_cnt),   160'(1));
    check("drop1_count", 160'(fifo_count), 160'(15));
    cycle(0, 0, 1, mk_pkt(3'b001), 1);
    cycle(0, 0, 1, mk_pkt(3'b001), 1);
    for (int i = 0; i < 15; i++) begin
      if (i == 13) check("ovf_set",   160'(tif.out_rec.ovf), 160'(1));
      if (i == 14) check("ovf_clear", 160'(tif.out_rec.ovf), 160'(0));
      cycle(0, 0, 1, idle, 1);
    end

    // Wrap: leave wptr at 15 with 12 entries, then a 3-lane push straddles 15->0
    cycle(0, 1, 0, idle, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, mk_pkt(3'b111), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, idle, 1);
    wp = mk_pkt(3'b111);
    cycle(0, 0, 1, wp, 0);
    check("wrap_count", 160'(fifo_count), 160'(15));
    for (int i = 0; i < 15; i++) begin
      if (i >= 12) check("wrap_order", 160'(tif.out_rec.insn), 160'(wp.trace_rv_i_insn_ip[32*(i-12) +: 32]));
      cycle(0, 0, 1, idle, 1);
    end

    // Full: simultaneous push and pop is still dropped
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, mk_pkt(3'b111), 0);
    cycle(0, 0, 1, mk_pkt(3'b001), 0);
    check("full_count", 160'(fifo_count),    160'(16));
    check("full_valid", 160'(tif.out_valid), 160'(1));
    cycle(0, 0, 1, mk_pkt(3'b100), 1);
    check("full_pp_count", 160'(fifo_count), 160'(15));
    check("full_pp_drop",  160'(drop_cnt),   160'(1));

    // Flush beats a same-cycle push and pop
    cycle(0, 1, 1, mk_pkt(3'b011), 1);
    check("flush_count", 160'(fifo_count),    160'(0));
    check("flush_valid", 160'(tif.out_valid), 160'(0));
    check("flush_drop",  160'(drop_cnt),      160'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 7) != 0), mk_pkt(3'($urandom)),
            ($urandom_range(0, 2) != 0));
    end

    // Drop counter saturation
    cycle(0, 1, 0, idle, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, mk_pkt(3'b111), 0);
    cycle(0, 0, 1, mk_pkt(3'b001), 0);
    for (int i = 0; i < DMAX + 5; i++) cycle(0, 0, 1, mk_pkt(3'b010), 0);
    check("drop_sat", 160'(drop_cnt), 160'(16'hFFFF));

`ifdef RV_TRACE_TIMESTAMP_EN
    // Records of one push share ts; separate pushes differ by the cycle gap
    cycle(0, 1, 0, idle, 0);
    cycle(0, 0, 1, mk_pkt(3'b111), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, idle, 0);
    cycle(0, 0, 1, mk_pkt(3'b011), 0);
    ts0 = tif.out_rec.ts; cycle(0, 0, 1, idle, 1);
    ts1 = tif.out_rec.ts; cycle(0, 0, 1, idle, 1);
    ts2 = tif.out_rec.ts; cycle(0, 0, 1, idle, 1);
    ts3 = tif.out_rec.ts; cycle(0, 0, 1, idle, 1);
    check("ts_same1", 160'(ts1),       160'(ts0));
    check("ts_same2", 160'(ts2),       160'(ts0));
    check("ts_gap",   160'(ts3 - ts0), 160'(4));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dec_trace_fifo.md
Name: dec_trace_fifo

Overview:
- Consumer of the per-cycle retire trace packet (trace_pkt_t, 3 lanes) produced by the decode/TLU stage.
- Buffers up to 3 retired-instruction records per cycle into a circular FIFO.
- Drains one record per cycle to an external trace port under valid/ready.
- The retire pipeline never stalls. On insufficient space the whole cycle's packet is dropped, counted, and flagged on the next record that is accepted.

Parameters:
- DEPTH, 16, FIFO entries. Must be a power of two, >= 4.
- DCNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- trace_en  in  1  1 = capture enabled. 0 = no pushes; the FIFO still drains.
- flush  in  1  synchronous clear of FIFO, drop counter and pending-overflow flag.
- trace_pkt  in  trace_pkt_t  per-cycle retire trace.
- out_valid  out  1  head record valid.
- out_ready  in  1  sink accepts the head record.
- out_rec  out  trace_rec_t  head record.
- drop_cnt  out  DCNT_W  saturating count of dropped packets.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - read/write pointers = 0, count = 0, drop_cnt = 0, ovf_pend = 0.
  - out_valid = 0, out_rec = 0.
- Lane n (n=0..2) carries:
  - insn[32n+31:32n], address[32n+31:32n], exception[n], interrupt[n].
  - ecause and tval are shared by all lanes.
- nv = popcount(trace_pkt.trace_rv_i_valid_ip) when trace_en=1, else 0.
- Space check uses pre-pop occupancy: accept iff nv != 0 and count + nv <= DEPTH. The same-cycle pop does not create space.
- Accepted push:
  - Valid lanes are written in ascending lane order at wptr, wptr+1, ... (mod DEPTH).
  - Invalid lanes are skipped with no holes.
  - wptr += nv.
- Rejected push (nv != 0, insufficient space):
  - No entries written.
  - drop_cnt += 1, saturating at all-ones.
  - ovf_pend <= 1.
- ovf flag:
  - The first record written by the next accepted push carries ovf=1, and ovf_pend clears in that cycle.
  - A new drop after that cycle sets ovf_pend again.
- Pop:
  - out_valid = (count != 0).
  - out_rec is read combinationally from the entry at rptr.
  - When out_valid and out_ready are both 1, rptr += 1.
  - out_ready while out_valid=0 has no effect.
- count_next = count + pushed − popped. Push and pop are allowed in the same cycle.
- Latency: a record pushed in cycle N is visible on out_rec in cycle N+1 at the earliest.
- Record field rules:
  - ecause and tval are copied into every record of the cycle.
  - exc = exception[n], intr = interrupt[n].
- Wrap-around:
  - Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Multi-entry writes may straddle index DEPTH−1 → 0.
- Full: count == DEPTH means out_valid=1, and every nonzero nv is dropped.
- Priority: rst > flush > push/pop.
  - flush clears everything the same way reset does; pushes and pops in that cycle are discarded.
  - out_valid is 0 the cycle after flush.
- trace_en is sampled each cycle. A deasserting edge does not drop in-flight entries.

Optional Feature:
- Macro: RV_TRACE_TIMESTAMP_EN.
- Defined:
  - trace_rec_t gains a 32-bit ts field.
  - A free-running 32-bit cycle counter wraps and resets to 0 on rst; flush does not clear it.
  - All records of one push carry the counter value of the push cycle.
- Undefined: no ts field and no counter; record width is 104 bits.

Decomposition:
- Add to the swerv_types package: typedef trace_rec_t, packed, MSB→LSB:
  - ovf 1, intr 1, exc 1, ecause 5, tval 32, addr 32, insn 32.
  - The ts 32 field is prepended under RV_TRACE_TIMESTAMP_EN.
- Sub-module dec_trace_fifo_mem:
  - register array with up to 3 write ports at consecutive modulo addresses and 1 combinational read port.
  - No reset on data.
- The parent holds pointers, count, drop logic and lane compaction.

Test Plan:
- Reset, then lane-valid 3'b101 with insn0=0x00000013, insn2=0x00100093 → next cycle fifo_count=2; out_rec.insn 0x13 then 0x00100093 in two accepted pops; ovf=0.
- Hold out_ready=0 and push 3 lanes per cycle; 6th push (count 15 + 3 > 16) → drop_cnt=1 and count stays 15. Then release out_ready and push 1 lane → that record has ovf=1; the following record has ovf=0.
- Wrap: DEPTH=16, prefill so wptr=15, push 3'b111 → entries written at indices 15, 0, 1; drain order matches lane order 0, 1, 2.
- Simultaneous push and pop at count=16 with nv=1 → dropped (pre-pop check); count=15 afterwards.
- flush asserted together with push 3'b011 and a pop → next cycle count=0, out_valid=0, drop_cnt=0.
- Force 65536 drops with DCNT_W=16 → drop_cnt saturates at 0xFFFF. With RV_TRACE_TIMESTAMP_EN defined, records of one push show equal ts, and ts values across pushes increase by the cycle gap.
